// File: rtl/assert_win_unchange_mc_pkg.sv
// Shared types and helpers for the multi-channel window-unchange checker.
package assert_win_unchange_mc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } win_state_e;

  localparam int FIRE_CHANGE  = 0;
  localparam int FIRE_TIMEOUT = 1;
  localparam int FIRE_TYPES   = 2;

  // Unsigned add clamped to max_val; callers keep counters at most 32 bits wide.
  function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                          input logic [31:0] inc,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    if (sum > {1'b0, max_val}) begin
      sat_add = max_val;
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

endpackage

// File: rtl/assert_win_unchange_chan.sv
// One checker channel: IDLE/OPEN FSM, snapshot, age counter and registered fires.
// Event ports exist only when OVL_WIN_UNCHANGE_COVER_EN is defined.
module assert_win_unchange_chan
  import assert_win_unchange_mc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_WIN = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start_event,
  input  logic                  end_event,
  input  logic [WIDTH-1:0]      test_expr,
  output logic                  window,
  output logic [FIRE_TYPES-1:0] fire,
  output logic [FIRE_TYPES-1:0] fire_nxt
`ifdef OVL_WIN_UNCHANGE_COVER_EN
  ,
  output logic                  open_evt,
  output logic                  close_evt
`endif
);

  localparam int AGE_W = (MAX_WIN > 0) ? $clog2(MAX_WIN + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WIN);

  win_state_e       state, state_nxt;
  logic [WIDTH-1:0] snap, snap_nxt;
  logic [AGE_W-1:0] age, age_nxt;
  logic             flagged, flagged_nxt;
  logic             timeout_hit;

  assign timeout_hit = (MAX_WIN > 0) && (age == AGE_MAX);
  assign window      = (state == ST_OPEN);

`ifdef OVL_WIN_UNCHANGE_COVER_EN
  assign open_evt  = (state == ST_IDLE) && start_event;
  assign close_evt = (state == ST_OPEN) && end_event;
`endif

  // Next-state logic; a close on the timeout cycle takes priority over the timeout.
  always_comb begin
    state_nxt   = state;
    snap_nxt    = snap;
    age_nxt     = age;
    flagged_nxt = flagged;
    fire_nxt    = {FIRE_TYPES{1'b0}};
    case (state)
      ST_IDLE: begin
        if (start_event) begin
          state_nxt   = ST_OPEN;
          snap_nxt    = test_expr;
          age_nxt     = {AGE_W{1'b0}};
          flagged_nxt = 1'b0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_OPEN: begin
        if ((test_expr != snap) && !flagged && enable) begin
          fire_nxt[FIRE_CHANGE] = 1'b1;
          flagged_nxt           = 1'b1;
        end else begin
          flagged_nxt = flagged;
        end
        if (end_event) begin
          state_nxt = ST_IDLE;
        end else if (timeout_hit) begin
          state_nxt              = ST_IDLE;
          fire_nxt[FIRE_TIMEOUT] = enable;
        end else if (MAX_WIN > 0) begin
          age_nxt = age + AGE_W'(1);
        end else begin
          age_nxt = age;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      snap    <= {WIDTH{1'b0}};
      age     <= {AGE_W{1'b0}};
      flagged <= 1'b0;
      fire    <= {FIRE_TYPES{1'b0}};
    end else begin
      state   <= state_nxt;
      snap    <= snap_nxt;
      age     <= age_nxt;
      flagged <= flagged_nxt;
      fire    <= fire_nxt;
    end
  end

endmodule

// File: rtl/assert_win_unchange_mc.sv
// Multi-channel window-unchange checker: NUM_CH channels plus fire OR and error counter.
// Define OVL_WIN_UNCHANGE_COVER_EN to add window open/close coverage counters.
module assert_win_unchange_mc
  import assert_win_unchange_mc_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 8,
  parameter int MAX_WIN = 0,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       start_event,
  input  logic [NUM_CH-1:0]       end_event,
  input  logic [NUM_CH*WIDTH-1:0] test_expr,
  output logic [NUM_CH-1:0]       window,
  output logic [NUM_CH-1:0]       fire_change,
  output logic [NUM_CH-1:0]       fire_timeout,
  output logic                    fire_any,
  output logic [CNT_W-1:0]        err_count
`ifdef OVL_WIN_UNCHANGE_COVER_EN
  ,
  output logic [CNT_W-1:0]        cov_open_count,
  output logic [CNT_W-1:0]        cov_close_count
`endif
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [FIRE_TYPES-1:0] fire_r   [NUM_CH];
  logic [FIRE_TYPES-1:0] fire_nxt [NUM_CH];
  logic [31:0]           fire_cnt;
  logic                  any_nxt;
`ifdef OVL_WIN_UNCHANGE_COVER_EN
  logic [NUM_CH-1:0]     open_evt, close_evt;
  logic [31:0]           open_cnt, close_cnt;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assert_win_unchange_chan #(
      .WIDTH   (WIDTH),
      .MAX_WIN (MAX_WIN)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .start_event (start_event[c]),
      .end_event   (end_event[c]),
      .test_expr   (test_expr[c*WIDTH +: WIDTH]),
      .window      (window[c]),
      .fire        (fire_r[c]),
      .fire_nxt    (fire_nxt[c])
`ifdef OVL_WIN_UNCHANGE_COVER_EN
      ,
      .open_evt    (open_evt[c]),
      .close_evt   (close_evt[c])
`endif
    );
    assign fire_change[c]  = fire_r[c][FIRE_CHANGE];
    assign fire_timeout[c] = fire_r[c][FIRE_TIMEOUT];
  end

  // Count and OR the fires being registered this cycle so fire_any/err_count align with them.
  always_comb begin
    fire_cnt = 32'd0;
    any_nxt  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int t = 0; t < FIRE_TYPES; t++) begin
        fire_cnt = fire_cnt + 32'(fire_nxt[c][t]);
        any_nxt  = any_nxt | fire_nxt[c][t];
      end
    end
  end

  // Aggregate fire flag and saturating error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      fire_any  <= 1'b0;
      err_count <= {CNT_W{1'b0}};
    end else begin
      fire_any  <= any_nxt;
      err_count <= CNT_W'(sat_add(32'(err_count), fire_cnt, CNT_MAX));
    end
  end

`ifdef OVL_WIN_UNCHANGE_COVER_EN
  // Popcount of window opens and normal closes across channels.
  always_comb begin
    open_cnt  = 32'd0;
    close_cnt = 32'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      open_cnt  = open_cnt + 32'(open_evt[c]);
      close_cnt = close_cnt + 32'(close_evt[c]);
    end
  end

  // Saturating coverage counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      cov_open_count  <= {CNT_W{1'b0}};
      cov_close_count <= {CNT_W{1'b0}};
    end else begin
      cov_open_count  <= CNT_W'(sat_add(32'(cov_open_count), open_cnt, CNT_MAX));
      cov_close_count <= CNT_W'(sat_add(32'(cov_close_count), close_cnt, CNT_MAX));
    end
  end
`endif

endmodule

// File: tb/tb_assert_win_unchange_mc.sv
// Scoreboard bench for assert_win_unchange_mc (4 channels, MAX_WIN=4) plus a
// 1-channel CNT_W=2 instance for counter saturation.
module tb_assert_win_unchange_mc;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int MW  = 4;
  localparam int CW  = 16;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [NCH-1:0]    start_event, end_event;
  logic [NCH*W-1:0]  test_expr;
  logic [NCH-1:0]    window, fire_change, fire_timeout;
  logic              fire_any;
  logic [CW-1:0]     err_count;

  logic              s_start, s_end;
  logic [7:0]        s_texpr;
  logic [0:0]        s_window, s_fc, s_ft;
  logic              s_any;
  logic [1:0]        s_err;

  assert_win_unchange_mc #(.NUM_CH(NCH), .WIDTH(W), .MAX_WIN(MW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .start_event(start_event), .end_event(end_event), .test_expr(test_expr),
    .window(window), .fire_change(fire_change), .fire_timeout(fire_timeout),
    .fire_any(fire_any), .err_count(err_count)
  );

  assert_win_unchange_mc #(.NUM_CH(1), .WIDTH(8), .MAX_WIN(0), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable),
    .start_event(s_start), .end_event(s_end), .test_expr(s_texpr),
    .window(s_window), .fire_change(s_fc), .fire_timeout(s_ft),
    .fire_any(s_any), .err_count(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] win;
    logic [NCH-1:0] fc;
    logic [NCH-1:0] ft;
    logic           any;
    logic [CW-1:0]  err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic       m_open [NCH];
  logic [7:0] m_snap [NCH];
  int         m_age  [NCH];
  logic       m_flag [NCH];
  int         m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for the edge that follows the currently driven inputs.
  task automatic model_step();
    exp_t e;
    int   nf;
    e.fc = '0;
    e.ft = '0;
    nf   = 0;
    for (int c = 0; c < NCH; c++) begin
      logic [7:0] sl;
      sl = test_expr[c*W +: W];
      if (reset) begin
        m_open[c] = 1'b0; m_snap[c] = 8'h00; m_age[c] = 0; m_flag[c] = 1'b0;
      end else if (!m_open[c]) begin
        if (start_event[c]) begin
          m_open[c] = 1'b1; m_snap[c] = sl; m_age[c] = 0; m_flag[c] = 1'b0;
        end
      end else begin
        if (sl != m_snap[c] && !m_flag[c] && enable) begin
          e.fc[c] = 1'b1; m_flag[c] = 1'b1; nf++;
        end
        if (end_event[c]) begin
          m_open[c] = 1'b0;
        end else if (m_age[c] == MW) begin
          m_open[c] = 1'b0;
          if (enable) begin
            e.ft[c] = 1'b1; nf++;
          end
        end else begin
          m_age[c]++;
        end
      end
      e.win[c] = m_open[c];
    end
    if (reset) m_err = 0;
    else m_err = (m_err + nf > 65535) ? 65535 : m_err + nf;
    if (reset) begin
      e.fc = '0; e.ft = '0;
    end
    e.any = (reset == 1'b0) && (nf != 0);
    e.err = CW'(m_err);
    sb_q.push_back(e);
  endtask

  task automatic cycle(input logic rst, input logic en, input logic [NCH-1:0] st,
                       input logic [NCH-1:0] ev, input logic [NCH*W-1:0] tx);
    exp_t e;
    reset = rst; enable = en; start_event = st; end_event = ev; test_expr = tx;
    model_step();
    @(posedge clk);
    #1;
    check_eq("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("window", window, e.win);
      check_eq("fire_change", fire_change, e.fc);
      check_eq("fire_timeout", fire_timeout, e.ft);
      check_eq("fire_any", fire_any, e.any);
      check_eq("err_count", err_count, e.err);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, compared=%0d", n_cmp);
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [31:0] base_err;
    logic [31:0] tx;
    s_start = 1'b0; s_end = 1'b0; s_texpr = 8'h00;

    // Reset and idle state
    cycle(1'b1, 1'b1, 4'h0, 4'h0, 32'h0);
    cycle(1'b1, 1'b1, 4'h0, 4'h0, 32'h0);
    check_eq("rst_err", err_count, 0);
    check_eq("rst_win", window, 0);
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h0);

    // Stable value over a window closed on age MAX_WIN: no fire, window high 5 samples
    cycle(1'b0, 1'b1, 4'h1, 4'h0, 32'h5A);
    check_eq("a_win0", window[0], 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h5A);
      check_eq("a_win", window[0], 1);
    end
    cycle(1'b0, 1'b1, 4'h0, 4'h1, 32'h5A);
    check_eq("a_close", window[0], 0);
    check_eq("a_noto", fire_timeout[0], 0);
    check_eq("a_err", err_count, 0);

    // Two changes in one window fire once
    cycle(1'b0, 1'b1, 4'h1, 4'h0, 32'h5A);
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h5A);
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h5A);
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h5B);
    check_eq("b_fire", fire_change[0], 1);
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h5C);
    check_eq("b_once", fire_change[0], 0);
    check_eq("b_open", window[0], 1);
    check_eq("b_err", err_count, 1);
    cycle(1'b0, 1'b1, 4'h0, 4'h1, 32'h5A);

    // Timeout after MAX_WIN with no end
    cycle(1'b0, 1'b1, 4'h1, 4'h0, 32'h5A);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h5A);
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h5A);
    check_eq("c_to", fire_timeout[0], 1);
    check_eq("c_win", window[0], 0);
    check_eq("c_err", err_count, 2);
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h5A);
    check_eq("c_to_pulse", fire_timeout[0], 0);

    // Two channels fire in the same cycle
    base_err = err_count;
    cycle(1'b0, 1'b1, 4'h8, 4'h0, 32'h3300_1100);
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h3300_1100);
    cycle(1'b0, 1'b1, 4'h2, 4'h0, 32'h3300_1100);
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h3300_1100);
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h3300_1100);
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h3300_1200);
    check_eq("d_fc", fire_change, 4'b0010);
    check_eq("d_ft", fire_timeout, 4'b1000);
    check_eq("d_any", fire_any, 1);
    check_eq("d_err", err_count, base_err + 2);
    cycle(1'b0, 1'b1, 4'h0, 4'h2, 32'h3300_1100);
    check_eq("d_quiet", fire_any, 0);

    // Start and end together in IDLE opens; reset mid-window suppresses the pending fire
    cycle(1'b0, 1'b1, 4'h4, 4'h4, 32'h0022_0000);
    check_eq("e_open", window, 4'b0100);
    cycle(1'b1, 1'b1, 4'h0, 4'h0, 32'h0023_0000);
    check_eq("e_fc", fire_change, 0);
    check_eq("e_win", window, 0);
    check_eq("e_err", err_count, 0);

    // enable low hides a change
    cycle(1'b0, 1'b1, 4'h1, 4'h0, 32'h5A);
    cycle(1'b0, 1'b0, 4'h0, 4'h0, 32'h5B);
    check_eq("f_fc", fire_change[0], 0);
    check_eq("f_err", err_count, 0);
    cycle(1'b0, 1'b1, 4'h0, 4'h1, 32'h5A);

    // Back-to-back windows take a fresh snapshot
    cycle(1'b0, 1'b1, 4'h1, 4'h0, 32'h10);
    cycle(1'b0, 1'b1, 4'h0, 4'h1, 32'h10);
    cycle(1'b0, 1'b1, 4'h1, 4'h0, 32'h20);
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h20);
    check_eq("g_nofire", fire_change[0], 0);
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h21);
    check_eq("g_fire", fire_change[0], 1);
    cycle(1'b0, 1'b1, 4'h0, 4'h1, 32'h21);

    // Random traffic against the model
    tx = 32'h0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) tx = tx ^ (32'd1 << $urandom_range(0, 31));
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
            4'($urandom_range(0, 15) & $urandom_range(0, 15)),
            4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)), tx);
    end

    // Saturation on the CNT_W=2 instance
    cycle(1'b1, 1'b1, 4'h0, 4'h0, 32'h0);
    check_eq("s_rst", s_err, 0);
    for (int i = 0; i < 5; i++) begin
      s_start = 1'b1; s_texpr = 8'h00;
      cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h0);
      s_start = 1'b0; s_texpr = 8'hFF;
      cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h0);
      check_eq("s_fc", s_fc, 1);
      check_eq("s_err", s_err, (i + 1 > 3) ? 3 : i + 1);
      s_end = 1'b1; s_texpr = 8'h00;
      cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h0);
      s_end = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/assert_win_unchange_mc.md
Name: assert_win_unchange_mc

Overview:
- Multi-channel, parametrised successor to the single-window unchange checker.
- Each of NUM_CH channels opens a window on its own start_event and snapshots its test_expr slice at that moment.
- While the window is open, the checker flags any change from the snapshot, and flags windows that stay open longer than MAX_WIN cycles.
- Sits beside the design under test as a synthesizable checker. Its fire outputs feed the OVL reporting layer or a formal harness.

Parameters:
- NUM_CH, 4: number of independent channels (1..32).
- WIDTH, 8: test_expr width per channel.
- MAX_WIN, 0: maximum open-window length in cycles; 0 disables the timeout check.
- CNT_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  global check enable; window tracking continues when low.
- start_event  input  NUM_CH  per-channel window open request.
- end_event  input  NUM_CH  per-channel window close request.
- test_expr  input  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- window  output  NUM_CH  per-channel window-open status.
- fire_change  output  NUM_CH  one-cycle pulse on the first change seen within a window.
- fire_timeout  output  NUM_CH  one-cycle pulse when a window exceeds MAX_WIN.
- fire_any  output  1  OR of all fire bits, registered in the same cycle as they are.
- err_count  output  CNT_W  total fires since reset, saturating.

Behaviour:
- Reset (reset=1 at a clk edge) clears window, fire_change, fire_timeout, fire_any, err_count, snapshots and age counters, all to 0.
- Per-channel FSM has two states, IDLE and OPEN.
- IDLE:
  - start_event=1 captures the test_expr slice into the snapshot and moves to OPEN; window=1 from the next cycle.
  - end_event in IDLE is ignored, including when it coincides with start_event (the window still opens).
- OPEN:
  - Every cycle, including the end_event cycle, test_expr is compared to the snapshot.
  - The first mismatch with enable=1 registers fire_change=1 for one cycle, and a per-window "flagged" bit suppresses further change fires for that window.
  - The window stays open after a mismatch; the snapshot is not updated.
  - start_event while OPEN is ignored.
  - end_event=1 returns the channel to IDLE; window=0 from the next cycle.
- Back-to-back windows: start_event in the first IDLE cycle after a close opens a fresh window with a new snapshot and a cleared flagged bit.
- Timeout (MAX_WIN>0):
  - The age counter resets to 0 on entering OPEN and increments each OPEN cycle.
  - When age reaches MAX_WIN without end_event, fire_timeout=1 (only if enable=1) and the channel forcibly returns to IDLE.
  - If end_event arrives in the same cycle age hits MAX_WIN, the close wins and no timeout fires.
  - The age counter width is clog2(MAX_WIN+1).
- Latency: all fire outputs are registered, one cycle after the offending sample.
- err_count adds the popcount of all fire bits each cycle and saturates at 2^CNT_W-1.
- enable=0 suppresses fires and counting only; FSMs, snapshots and window are unaffected.
- Reset mid-window aborts the window without firing.

Optional Feature:
- Macro OVL_WIN_UNCHANGE_COVER_EN.
- When defined, adds outputs cov_open_count and cov_close_count (CNT_W each, saturating). These count windows opened and normally closed across all channels, and are reset by reset.
- When undefined, the ports and logic are absent.

Decomposition:
- Package assert_win_unchange_mc_pkg holds:
  - the state enum (ST_IDLE, ST_OPEN);
  - fire-type constants (FIRE_CHANGE=0, FIRE_TIMEOUT=1);
  - a saturating-add function.
- Sub-module assert_win_unchange_chan holds one channel's FSM, snapshot, age counter and fire bits. The top generates NUM_CH instances and does the OR, popcount and counters.

Test Plan:
- NUM_CH=1, WIDTH=8: start with test_expr=0x5A, hold 0x5A for 5 cycles, then end -> no fire; window high for 5 cycles; err_count=0.
- Window open with snapshot 0x5A; test_expr=0x5B on cycle 3 and 0x5C on cycle 4 -> fire_change pulses once, one cycle after cycle 3; err_count=1; window stays open until end.
- MAX_WIN=4: start, no end for 6 cycles -> fire_timeout after 4 open cycles; window=0 next cycle. Repeat with end arriving on age 4 -> no timeout.
- NUM_CH=4: channel 1 changes and channel 3 times out in the same cycle -> fire_change[1] and fire_timeout[3] both pulse, fire_any=1, err_count advances by 2; channels 0 and 2 stay silent.
- Simultaneous start+end in IDLE -> window opens. Assert reset mid-window with a pending change -> no fire, window=0, err_count=0.
- enable=0 during a change -> no fire. CNT_W=2 with 5 fires -> err_count saturates at 3.
